// File: rtl/ov7670_yuv_capture_pkg.sv
// Shared definitions for the OV7670 YUV422 capture path: FSM states, byte phases
// and the default active-window size used by the framebuffer and vga blocks.
package ov7670_yuv_capture_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    BLANK      = 2'd1,
    ACTIVE     = 2'd2
  } cap_state_t;

  typedef enum logic [1:0] {
    PH_Y0 = 2'd0,
    PH_CB = 2'd1,
    PH_Y1 = 2'd2,
    PH_CR = 2'd3
  } byte_phase_t;

endpackage

// File: rtl/ov7670_yuv_capture_addr_gen.sv
// Framebuffer address generator: accumulates a per-line base address and a pixel
// offset within the line; flags whether the next pair still fits the active window.
module cap_addr_gen
  import ov7670_yuv_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_end,
  input  logic              pair_write,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range,
  output logic [9:0]        line
);

  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] pix;

  // pix stops at H_ACTIVE and line_base stops advancing past the last line,
  // so neither can wrap back into the window on oversized input.
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      line_base <= '0;
      pix       <= '0;
      line      <= '0;
    end else if (line_end) begin
      pix <= '0;
      if (line < 10'(V_ACTIVE))
        line_base <= line_base + ADDR_W'(H_ACTIVE);
      if (line != '1)
        line <= line + 10'd1;
    end else if (pair_write) begin
      pix <= pix + ADDR_W'(2);
    end
  end

  assign addr     = line_base + pix;
  assign in_range = (pix < ADDR_W'(H_ACTIVE)) && (line < 10'(V_ACTIVE));

endmodule

// File: rtl/ov7670_yuv_capture.sv
// OV7670 DVP capture front end: assembles Y0 Cb Y1 Cr pairs, emits a two-cycle
// framebuffer write burst per pair, and frames everything on VSYNC/HREF.
module ov7670_yuv_capture
  import ov7670_yuv_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              PCLK,
  input  logic              reset,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        D,
  output logic [7:0]        Y,
  output logic [7:0]        Y_2,
  output logic [7:0]        Cb,
  output logic [7:0]        Cr,
  output logic              e_pix,
  output logic              e_data,
  output logic [ADDR_W-1:0] CONTADOR_C,
  output logic              frame_done,
  output logic [9:0]        line_count,
  output logic              overflow
);

  logic        v_q, h_q, v_prev, h_prev;
  logic [7:0]  d_q;
  cap_state_t  state, state_nxt;
  byte_phase_t phase;
  logic        frame_start, frame_end, line_end, take;
  logic        pair_done, pair_write, in_range;
  logic [7:0]  y_hold, cb_hold, y2_hold;
  logic        wr_first, wr_second;
  logic [ADDR_W-1:0] addr, wr_addr;
  logic [9:0]  line;

  always_ff @(posedge PCLK) begin
    if (reset) begin
      v_q    <= 1'b0;
      h_q    <= 1'b0;
      d_q    <= '0;
      v_prev <= 1'b0;
      h_prev <= 1'b0;
    end else begin
      v_q    <= VSYNC;
      h_q    <= HREF;
      d_q    <= D;
      v_prev <= v_q;
      h_prev <= h_q;
    end
  end

  always_ff @(posedge PCLK) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    line_end    = 1'b0;
    take        = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (v_q && !v_prev) begin
          state_nxt   = BLANK;
          frame_start = 1'b1;
        end
      end
      BLANK: begin
        if (v_q && !v_prev) begin
          frame_start = 1'b1;
        end else if (!v_q && h_q) begin
          state_nxt = ACTIVE;
          take      = 1'b1;
        end
      end
      ACTIVE: begin
        // A line end coinciding with the frame end is still counted.
        line_end = h_prev && !h_q;
        take     = h_q && !(v_q && !v_prev);
        if (v_q && !v_prev) begin
          frame_end   = 1'b1;
          frame_start = 1'b1;
          state_nxt   = BLANK;
        end
      end
      default: state_nxt = WAIT_FRAME;
    endcase
  end

  assign pair_done  = take && (phase == PH_CR);
  assign pair_write = pair_done && in_range;

  cap_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk         (PCLK),
    .reset       (reset),
    .frame_start (frame_start),
    .line_end    (line_end),
    .pair_write  (pair_write),
    .addr        (addr),
    .in_range    (in_range),
    .line        (line)
  );

  // The burst address is latched at pair completion, so a line end landing
  // mid-burst cannot disturb the second write.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      phase      <= PH_Y0;
      y_hold     <= '0;
      cb_hold    <= '0;
      y2_hold    <= '0;
      Y          <= '0;
      Y_2        <= '0;
      Cb         <= '0;
      Cr         <= '0;
      e_pix      <= 1'b0;
      e_data     <= 1'b0;
      CONTADOR_C <= '0;
      frame_done <= 1'b0;
      line_count <= '0;
      overflow   <= 1'b0;
      wr_first   <= 1'b0;
      wr_second  <= 1'b0;
      wr_addr    <= '0;
    end else begin
      e_pix      <= 1'b0;
      e_data     <= 1'b0;
      frame_done <= 1'b0;
      wr_first   <= pair_write;
      wr_second  <= wr_first;

      if (frame_start || line_end)
        phase <= PH_Y0;
      else if (take)
        phase <= byte_phase_t'(phase + 2'd1);

      if (take) begin
        case (phase)
          PH_Y0: y_hold  <= d_q;
          PH_CB: cb_hold <= d_q;
          PH_Y1: y2_hold <= d_q;
          PH_CR: begin
            Y     <= y_hold;
            Cb    <= cb_hold;
            Y_2   <= y2_hold;
            Cr    <= d_q;
            e_pix <= 1'b1;
            if (!in_range) overflow <= 1'b1;
          end
          default: ;
        endcase
      end

      if (pair_write) wr_addr <= addr;

      if (wr_first) begin
        e_data     <= 1'b1;
        CONTADOR_C <= wr_addr;
      end else if (wr_second) begin
        e_data     <= 1'b1;
        CONTADOR_C <= wr_addr + ADDR_W'(1);
      end

      if (frame_end) begin
        frame_done <= 1'b1;
        line_count <= (line_end && line != '1) ? line + 10'd1 : line;
      end
    end
  end

endmodule
